// File: rtl/serial_word_comparator_pkg.sv
// Shared types and constants for the serial word comparator.
package serial_word_comparator_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [1:0] SEL_EQ   = 2'b00;
   localparam logic [1:0] SEL_LT   = 2'b10;
   localparam logic [1:0] SEL_GT   = 2'b01;
   localparam logic [1:0] SEL_NONE = 2'b11;

   // Pick the flag named by a select code; the "none" code yields 0.
   function automatic logic sel_flag(input logic [1:0] sel, input logic f_lt,
                                     input logic f_eq, input logic f_gt);
      logic f;
      case (sel)
         SEL_EQ:   f = f_eq;
         SEL_LT:   f = f_lt;
         SEL_GT:   f = f_gt;
         SEL_NONE: f = 1'b0;
         default:  f = 1'b0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/serial_word_comparator_nibble_cmp.sv
// Combinational 4-bit unsigned comparator; exactly one of lt/eq/gt is high.
module serial_word_comparator_nibble_cmp
   import serial_word_comparator_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   output logic                lt,
   output logic                eq,
   output logic                gt
);

   assign lt = (a < b);
   assign eq = (a == b);
   assign gt = (a > b);

endmodule

// File: rtl/serial_word_comparator.sv
// Multi-cycle magnitude comparator: walks operands MSB nibble first and
// stops at the first unequal nibble, with valid/ready on both sides.
module serial_word_comparator
   import serial_word_comparator_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0]  a,
   input  logic [NIBBLE_W*NIBBLES-1:0]  b,
   input  logic [1:0]                   sel,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         lt,
   output logic                         eq,
   output logic                         gt,
   output logic                         result
);

   localparam int unsigned W     = NIBBLE_W * NIBBLES;
   localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_e             state_q, state_d;
   logic [W-1:0]       a_q, a_d;
   logic [W-1:0]       b_q, b_d;
   logic [1:0]         sel_q, sel_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               lt_q, lt_d;
   logic               eq_q, eq_d;
   logic               gt_q, gt_d;
   logic               result_q, result_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;

   logic [NIBBLE_W-1:0] nib_a;
   logic [NIBBLE_W-1:0] nib_b;
   logic                cmp_lt;
   logic                cmp_eq;
   logic                cmp_gt;

   // Select the nibble pair addressed by the scan index.
   always_comb begin
      nib_a = '0;
      nib_b = '0;
      for (int unsigned i = 0; i < NIBBLES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
            nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   serial_word_comparator_nibble_cmp u_nibble_cmp (
      .a  (nib_a),
      .b  (nib_b),
      .lt (cmp_lt),
      .eq (cmp_eq),
      .gt (cmp_gt)
   );

   // Next-state and registered-output computation.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sel_d    = sel_q;
      idx_d    = idx_q;
      lt_d     = lt_q;
      eq_d     = eq_q;
      gt_d     = gt_q;
      result_d = result_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               sel_d   = sel;
               idx_d   = IDX_W'(NIBBLES - 1);
               state_d = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (cmp_lt) begin
               lt_d     = 1'b1;
               eq_d     = 1'b0;
               gt_d     = 1'b0;
               result_d = sel_flag(sel_q, 1'b1, 1'b0, 1'b0);
               state_d  = ST_DONE;
            end else if (cmp_gt) begin
               lt_d     = 1'b0;
               eq_d     = 1'b0;
               gt_d     = 1'b1;
               result_d = sel_flag(sel_q, 1'b0, 1'b0, 1'b1);
               state_d  = ST_DONE;
            end else if (cmp_eq) begin
               if (idx_q == '0) begin
                  lt_d     = 1'b0;
                  eq_d     = 1'b1;
                  gt_d     = 1'b0;
                  result_d = sel_flag(sel_q, 1'b0, 1'b1, 1'b0);
                  state_d  = ST_DONE;
               end else begin
                  idx_d = idx_q - IDX_W'(1);
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               lt_d     = 1'b0;
               eq_d     = 1'b0;
               gt_d     = 1'b0;
               result_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   // State and datapath registers; reset discards any captured operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         idx_q       <= '0;
         lt_q        <= 1'b0;
         eq_q        <= 1'b0;
         gt_q        <= 1'b0;
         result_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sel_q       <= sel_d;
         idx_q       <= idx_d;
         lt_q        <= lt_d;
         eq_q        <= eq_d;
         gt_q        <= gt_d;
         result_q    <= result_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign lt        = lt_q;
   assign eq        = eq_q;
   assign gt        = gt_q;
   assign result    = result_q;

endmodule

// File: tb/tb_serial_word_comparator.sv
// Self-checking bench for serial_word_comparator (NIBBLES=4).
module tb_serial_word_comparator;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [1:0]     sel;
   logic           out_valid;
   logic           out_ready;
   logic           lt;
   logic           eq;
   logic           gt;
   logic           result;

   int n_pass  = 0;
   int n_total = 0;
   bit mon_en  = 1'b0;

   always #5 clk = ~clk;

   serial_word_comparator #(.NIBBLES(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .lt        (lt),
      .eq        (eq),
      .gt        (gt),
      .result    (result)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   sel;
      logic         exp_lt;
      logic         exp_eq;
      logic         exp_gt;
      logic         exp_res;
      int           exp_lat;
      int           hold;
   } vec_t;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Position (1 = MSB nibble) of the first differing nibble; N if equal.
   function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      d = x ^ y;
      for (int i = W - 1; i >= 0; i--) begin
         if (d[i]) return N - i / 4;
      end
      return N;
   endfunction

   function automatic logic model_res(input logic [1:0] s, input logic [W-1:0] x,
                                      input logic [W-1:0] y);
      case (s)
         2'b00:   return x == y;
         2'b10:   return x < y;
         2'b01:   return x > y;
         default: return 1'b0;
      endcase
   endfunction

   // Handshake and flag invariants, sampled away from the active edge.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         check("inv_ready_and_valid", int'(in_ready && out_valid), 0);
         check("inv_flags",
               out_valid ? int'(lt) + int'(eq) + int'(gt) : int'(lt | eq | gt | result),
               out_valid ? 1 : 0);
      end
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            return;
         end
         @(posedge clk); #1;
      end
      check("in_ready_timeout", 0, 1);
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      bit ok;
      int lat;
      wait_ready(ok);
      if (!ok) return;
      a = v.a; b = v.b; sel = v.sel; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); sel = 2'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, lat, v.exp_lat);
      check({tag, "_lt"}, int'(lt), int'(v.exp_lt));
      check({tag, "_eq"}, int'(eq), int'(v.exp_eq));
      check({tag, "_gt"}, int'(gt), int'(v.exp_gt));
      check({tag, "_result"}, int'(result), int'(v.exp_res));
      check({tag, "_in_ready_done"}, int'(in_ready), 0);
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, int'(out_valid), 1);
         check({tag, "_hold_flags"}, int'({lt, eq, gt, result}),
               int'({v.exp_lt, v.exp_eq, v.exp_gt, v.exp_res}));
         check({tag, "_hold_in_ready"}, int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_release_valid"}, int'(out_valid), 0);
      check({tag, "_release_in_ready"}, int'(in_ready), 1);
      check({tag, "_release_flags"}, int'({lt, eq, gt, result}), 0);
   endtask

   initial begin
      vec_t tbl[10];
      vec_t v;
      bit ok;
      bit acc_now;
      bit seen;
      int accepts;
      int p;
      logic [2:0] resp[$];

      tbl[0] = '{16'h8000, 16'h0001, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0};
      tbl[1] = '{16'hBEEF, 16'hBEEF, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 4, 0};
      tbl[2] = '{16'hBEEF, 16'hBEEF, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 4, 0};
      tbl[3] = '{16'h5550, 16'h5551, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 4, 0};
      tbl[4] = '{16'h5550, 16'h5551, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0};
      tbl[5] = '{16'h0F00, 16'h0E00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 2, 5};
      tbl[6] = '{16'h1234, 16'h1334, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1};
      tbl[7] = '{16'hABCD, 16'hABC0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 4, 2};
      tbl[8] = '{16'h0000, 16'hFFFF, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
      tbl[9] = '{16'hFFFF, 16'h0000, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sel = '0;
      @(posedge clk); #1;
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_flags", int'({lt, eq, gt, result}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mon_en = 1'b1;

      // Directed vectors
      for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

      // Back-to-back with in_valid held high
      wait_ready(ok);
      a = 16'd1; b = 16'd2; sel = 2'b10; in_valid = 1'b1; out_ready = 1'b1;
      accepts = 0;
      for (int c = 0; c < 30; c++) begin
         acc_now = in_ready && in_valid;
         @(posedge clk); #1;
         if (acc_now) begin
            accepts++;
            if (accepts == 1) begin
               a = 16'd3; b = 16'd3; sel = 2'b00;
            end else begin
               check("b2b_second_after_first", resp.size(), 1);
               in_valid = 1'b0;
            end
         end
         if (out_valid) resp.push_back({lt, eq, gt});
      end
      out_ready = 1'b0;
      in_valid = 1'b0;
      check("b2b_accepts", accepts, 2);
      check("b2b_responses", resp.size(), 2);
      if (resp.size() >= 2) begin
         check("b2b_first_lt", int'(resp[0]), int'(3'b100));
         check("b2b_second_eq", int'(resp[1]), int'(3'b010));
      end

      // Randomized against the reference model
      for (int t = 0; t < 150; t++) begin
         v.a = W'($urandom);
         v.b = W'($urandom);
         case ($urandom_range(0, 2))
            0: v.b = v.a;
            1: begin
               p = $urandom_range(0, N - 1);
               v.b = v.a;
               v.b[p*4 +: 4] = v.a[p*4 +: 4] ^ 4'($urandom_range(1, 15));
               for (int j = 0; j < p; j++) v.b[j*4 +: 4] = 4'($urandom);
            end
            default: ;
         endcase
         v.sel     = 2'($urandom);
         v.exp_lt  = v.a < v.b;
         v.exp_eq  = v.a == v.b;
         v.exp_gt  = v.a > v.b;
         v.exp_res = model_res(v.sel, v.a, v.b);
         v.exp_lat = model_lat(v.a, v.b);
         v.hold    = $urandom_range(0, 3);
         run_txn(v, "rand");
      end

      // Reset while scanning discards the pair
      wait_ready(ok);
      a = 16'h1234; b = 16'h1235; sel = 2'b10; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midscan_rst_in_ready", int'(in_ready), 1);
      check("midscan_rst_out_valid", int'(out_valid), 0);
      check("midscan_rst_flags", int'({lt, eq, gt, result}), 0);
      #3;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         seen |= out_valid;
      end
      check("midscan_no_out_valid", int'(seen), 0);
      check("midscan_in_ready_after", int'(in_ready), 1);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/serial_word_comparator.md
Name: serial_word_comparator

Overview:
- Multi-cycle magnitude comparator for wide unsigned operands, built on the team's 4-bit nibble comparison.
- Accepts an operand pair and a select code through a valid/ready handshake.
- Walks the operands one nibble per cycle, most significant nibble first, and stops at the first unequal nibble.
- Presents lt/eq/gt plus the selected result bit downstream under a second valid/ready handshake.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair and sel are valid
- in_ready  output  1  block can accept a new pair
- a  input  W  operand A, unsigned
- b  input  W  operand B, unsigned
- sel  input  2  result select: 00=eq, 10=lt, 01=gt, 11=none
- out_valid  output  1  lt/eq/gt/result are valid
- out_ready  input  1  downstream consumes the result
- lt  output  1  A < B
- eq  output  1  A == B
- gt  output  1  A > B
- result  output  1  flag chosen by the captured sel; 0 when sel=11

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; lt=eq=gt=result=0.
  - Any captured operands are discarded, including during SCAN or DONE.
- FSM states: IDLE, SCAN, DONE. All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1.
  - When in_valid=1, capture a, b and sel, load idx=NIBBLES-1, and go to SCAN.
- SCAN:
  - in_ready=0. Each cycle, compare a[4*idx+3:4*idx] with b[4*idx+3:4*idx].
  - A nibble < B nibble: set lt=1, eq=gt=0; go to DONE.
  - A nibble > B nibble: set gt=1, lt=eq=0; go to DONE.
  - Nibbles equal and idx==0: set eq=1, lt=gt=0; go to DONE.
  - Nibbles equal and idx>0: decrement idx; stay in SCAN.
- DONE:
  - out_valid=1; result = (sel==00)?eq : (sel==10)?lt : (sel==01)?gt : 0.
  - All outputs hold stable while out_ready=0.
  - When out_ready=1, go to IDLE and clear out_valid, lt, eq, gt and result.
  - There is no same-cycle accept: in_ready rises the cycle after the DONE→IDLE transition.
- Latency:
  - If the first mismatch is found at nibble position k (counting from the MSB, k=1..NIBBLES), out_valid rises k cycles after the accept edge.
  - Equal operands take NIBBLES cycles.
- Invariants:
  - Exactly one of lt/eq/gt is 1 whenever out_valid=1; all three are 0 otherwise.
  - in_ready and out_valid are never both 1.
- Boundary conditions:
  - NIBBLES=1 gives a single SCAN cycle.
  - Inputs a, b and sel are ignored outside an IDLE accept; changes during SCAN or DONE have no effect.
  - in_valid held high through DONE is accepted only once the block returns to IDLE.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - sel codes SEL_EQ=2'b00, SEL_LT=2'b10, SEL_GT=2'b01, SEL_NONE=2'b11;
  - NIBBLE_W=4.
- Sub-module nibble_cmp:
  - purely combinational 4-bit unsigned comparator with outputs lt/eq/gt, exactly one high;
  - instantiated once and fed by an idx-indexed nibble mux.
- Idx counter width: clog2(NIBBLES), minimum 1.

Test Plan:
- Reset mid-SCAN: NIBBLES=4, accept a=16'h1234, b=16'h1235, assert rst_n=0 after 2 cycles -> state IDLE, in_ready=1, out_valid=0, lt=eq=gt=result=0 immediately; no out_valid follows after release.
- Early exit: a=16'h8000, b=16'h0001, sel=01 -> out_valid 1 cycle after accept; gt=1, lt=0, eq=0, result=1.
- Full scan, equal operands: a=b=16'hBEEF, sel=00 -> out_valid 4 cycles after accept; eq=1, result=1. Same operands with sel=10 -> result=0.
- LSB decides: a=16'h5550, b=16'h5551, sel=10 -> out_valid 4 cycles after accept; lt=1, result=1. With sel=11 -> lt=1, result=0.
- Backpressure: a=16'h0F00, b=16'h0E00 with out_ready=0 for 5 cycles -> out_valid, gt=1 and result held stable for all 5 cycles, in_ready=0; after out_ready=1 for one cycle, out_valid=0 and in_ready=1 on the next cycle.
- Back-to-back with in_valid held high: two pairs (1,2) then (3,3) -> second pair accepted only after in_ready returns; the responses arrive in order as lt=1, then eq=1; no pair is lost or duplicated.
